mem_access_resp: RTL and testbench
==================================

MEM_ACCESS_RESP -- requirements
Module: mem_access_resp

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, meaning clock cycles from Data_addr driven to Data_dout valid (legal 1..15).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request from controller, sampled only in IDLE.
REQ-005 SHALL have port mem_state  input  2  access type: 0 read, 1 read-indirect, 2 write, 3 none.
REQ-006 SHALL have port M_addr  input  16  effective address, sampled with start.
REQ-007 SHALL have port M_data  input  16  store data, sampled with start.
REQ-008 SHALL have port Data_dout  input  16  data-memory read data.
REQ-009 SHALL have port Data_addr  output  16  data-memory address.
REQ-010 SHALL have port Data_din  output  16  data-memory write data.
REQ-011 SHALL have port Data_rd  output  1  1 read, 0 write.
REQ-012 SHALL have port Data_en  output  1  data-memory access strobe.
REQ-013 SHALL have port memout  output  16  last completed read value.
REQ-014 SHALL have port complete_data  output  1  one-cycle completion pulse to controller.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port acc_count  output  16  completed-access counter (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, RD_WAIT, IND_WAIT, WR, DONE; all outputs registered.
REQ-018 IDLE: start=1 with mem_state 0 -> RD_WAIT; 1 -> IND_WAIT; 2 -> WR; 3 -> stay IDLE, no completion.
REQ-019 On accepted start SHALL latch M_addr into Data_addr, M_data into Data_din; Data_en=1; Data_rd=0 for write, else 1.
REQ-020 RD_WAIT: latency counter counts MEM_LATENCY cycles, then latches Data_dout into memout, drops Data_en, -> DONE.
REQ-021 IND_WAIT: after MEM_LATENCY cycles latches Data_dout into Data_addr (pointer), keeps Data_en=1, -> RD_WAIT with counter reloaded.
REQ-022 WR: Data_en high exactly one cycle, then -> DONE; memout unchanged.
REQ-023 DONE: complete_data=1 for exactly one cycle, -> IDLE; start in DONE SHALL be ignored.
REQ-024 Read latency: complete_data SHALL rise MEM_LATENCY+1 edges after start edge; indirect 2*(MEM_LATENCY+1)+... edges = 2*MEM_LATENCY+2; write 2 edges.
REQ-025 start while busy=1 SHALL be ignored (no queueing, no state change).
REQ-026 Data_din, Data_addr SHALL hold last value when Data_en=0; memout holds until next read completes.
REQ-027 Indirect with pointer equal to M_addr SHALL behave identically (no special case).

Reset
REQ-028 reset asserted SHALL immediately force IDLE, Data_addr=0, Data_din=0, Data_rd=1, Data_en=0, memout=0, complete_data=0, busy=0, acc_count=0.
REQ-029 reset mid-access SHALL abort it with no complete_data pulse; first start after deassertion SHALL be accepted normally.

Configuration
REQ-030 With macro MEM_ACCESS_RESP_CNT_EN defined, acc_count SHALL increment by 1 on each complete_data pulse, saturating at 16'hFFFF.
REQ-031 Without MEM_ACCESS_RESP_CNT_EN, acc_count SHALL be constant 0 and no counter logic synthesized; all other behaviour identical.

Verification
REQ-032 Read, MEM_LATENCY=1: start, mem_state=0, M_addr=16'h3000, Data_dout=16'hBEEF -> Data_addr=3000, Data_rd=1, complete_data pulse 2 edges after start, memout=BEEF.
REQ-033 Indirect: M_addr=16'h3010, mem[3010]=16'h4000, mem[4000]=16'h1234 -> Data_addr 3010 then 4000, memout=1234, complete_data at edge 4.
REQ-034 Write: M_addr=16'h3020, M_data=16'h00A5 -> Data_en one cycle, Data_rd=0, Data_din=00A5, complete_data at edge 2, memout unchanged.
REQ-035 start during RD_WAIT with mem_state=2 -> ignored, single completion, no write strobe; mem_state=3 start -> no completion.
REQ-036 reset asserted in IND_WAIT -> outputs at reset values same cycle, no complete_data; next read completes normally.
REQ-037 With MEM_ACCESS_RESP_CNT_EN, 3 completed accesses -> acc_count=3; without it acc_count=0 throughout.

Source files
------------

// File: rtl/mem_access_resp.sv
// Data-memory access sequencer: read, read-indirect and write with a fixed memory latency.
// Optional completed-access counter is enabled by defining MEM_ACCESS_RESP_CNT_EN.
module mem_access_resp #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mem_state,
    input  logic [15:0] M_addr,
    input  logic [15:0] M_data,
    input  logic [15:0] Data_dout,
    output logic [15:0] Data_addr,
    output logic [15:0] Data_din,
    output logic        Data_rd,
    output logic        Data_en,
    output logic [15:0] memout,
    output logic        complete_data,
    output logic        busy,
    output logic [15:0] acc_count
);

    // Handshake: start is a one-cycle request honoured only while busy is low; every
    // accepted request (mem_state 0..2) is answered by exactly one complete_data pulse.
    typedef enum logic [2:0] {IDLE, RD_WAIT, IND_WAIT, WR, DONE} state_t;

    // Wait counters count down to zero; the pointer phase carries one extra turnaround cycle.
    localparam logic [3:0] RD_LOAD  = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] IND_LOAD = 4'(MEM_LATENCY);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] addr_nxt, din_nxt, memout_nxt;
    logic        rd_nxt, en_nxt, done_nxt, busy_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            Data_addr     <= '0;
            Data_din      <= '0;
            Data_rd       <= 1'b1;
            Data_en       <= 1'b0;
            memout        <= '0;
            complete_data <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            Data_addr     <= addr_nxt;
            Data_din      <= din_nxt;
            Data_rd       <= rd_nxt;
            Data_en       <= en_nxt;
            memout        <= memout_nxt;
            complete_data <= done_nxt;
            busy          <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        addr_nxt   = Data_addr;
        din_nxt    = Data_din;
        rd_nxt     = Data_rd;
        en_nxt     = Data_en;
        memout_nxt = memout;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (start && (mem_state != 2'd3)) begin
                    addr_nxt = M_addr;
                    din_nxt  = M_data;
                    en_nxt   = 1'b1;
                    rd_nxt   = (mem_state != 2'd2);
                    case (mem_state)
                        2'd0: begin
                            state_nxt = RD_WAIT;
                            cnt_nxt   = RD_LOAD;
                        end
                        2'd1: begin
                            state_nxt = IND_WAIT;
                            cnt_nxt   = IND_LOAD;
                        end
                        default: state_nxt = WR;
                    endcase
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd0) begin
                    memout_nxt = Data_dout;
                    en_nxt     = 1'b0;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            IND_WAIT: begin
                // The fetched word becomes the address of the second read; strobe stays up.
                if (cnt == 4'd0) begin
                    addr_nxt  = Data_dout;
                    cnt_nxt   = RD_LOAD;
                    state_nxt = RD_WAIT;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WR: begin
                en_nxt    = 1'b0;
                state_nxt = DONE;
            end
            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

`ifdef MEM_ACCESS_RESP_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_count <= '0;
        end else if (done_nxt && (acc_count != 16'hFFFF)) begin
            acc_count <= acc_count + 16'd1;
        end
    end
`else
    assign acc_count = '0;
`endif

endmodule

// File: tb/tb_mem_access_resp.sv
// Bench for mem_access_resp: latency-aware memory, transaction-timeline model checked every
// cycle, directed literal scenarios followed by randomized traffic.
module tb_mem_access_resp;

  localparam int LAT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mem_state;
  logic [15:0] M_addr, M_data, Data_dout;
  logic [15:0] Data_addr, Data_din, memout, acc_count;
  logic        Data_rd, Data_en, complete_data, busy;

  mem_access_resp #(.MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .mem_state(mem_state),
    .M_addr(M_addr), .M_data(M_data), .Data_dout(Data_dout),
    .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd), .Data_en(Data_en),
    .memout(memout), .complete_data(complete_data), .busy(busy), .acc_count(acc_count)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:65535];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int dut_done_cnt = 0;

  // model: one outstanding transaction described by its start edge and type
  logic        m_active;
  int          m_e;
  logic [1:0]  m_type;
  logic [15:0] m_a, m_ptr;
  logic [15:0] e_addr, e_din, e_memout, e_acc;
  logic        e_rd, e_en, e_busy, e_done;

  logic [15:0] last_addr = 16'h0;
  int          age = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    e_addr = 16'h0; e_din = 16'h0; e_memout = 16'h0; e_acc = 16'h0;
    e_rd = 1'b1; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0;
  endtask

  task automatic finish_txn();
    m_active = 1'b0;
    e_done = 1'b1;
`ifdef MEM_ACCESS_RESP_CNT_EN
    if (e_acc != 16'hFFFF) e_acc = e_acc + 16'd1;
`endif
  endtask

  task automatic compare_all();
    chk("busy", {15'd0, busy}, {15'd0, e_busy});
    chk("complete_data", {15'd0, complete_data}, {15'd0, e_done});
    chk("Data_en", {15'd0, Data_en}, {15'd0, e_en});
    chk("Data_rd", {15'd0, Data_rd}, {15'd0, e_rd});
    chk("Data_addr", Data_addr, e_addr);
    chk("Data_din", Data_din, e_din);
    chk("memout", memout, e_memout);
    chk("acc_count", acc_count, e_acc);
  endtask

  // One clock edge: memory write, model update, compare, then memory read data for next edge.
  task automatic step();
    logic s, r, wr, accept;
    logic [1:0] ms;
    logic [15:0] ma, md, wa, wd;
    int k;
    s = start; r = reset; ms = mem_state; ma = M_addr; md = M_data;
    wr = Data_en && !Data_rd; wa = Data_addr; wd = Data_din;
    @(posedge clock);
    cyc++;
    if (wr && !r) mem[wa] = wd;
    e_done = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      accept = !m_active && s && (ms != 2'd3);
      if (m_active) begin
        k = cyc - m_e;
        case (m_type)
          2'd0: begin
            if (k == LAT) begin e_memout = mem[m_a]; e_en = 1'b0; end
            if (k == LAT + 1) finish_txn();
          end
          2'd1: begin
            if (k == LAT + 1) begin m_ptr = mem[m_a]; e_addr = m_ptr; end
            if (k == 2 * LAT + 1) begin e_memout = mem[m_ptr]; e_en = 1'b0; end
            if (k == 2 * LAT + 2) finish_txn();
          end
          default: begin
            if (k == 1) e_en = 1'b0;
            if (k == 2) finish_txn();
          end
        endcase
      end
      if (accept) begin
        m_active = 1'b1; m_e = cyc; m_type = ms; m_a = ma;
        e_addr = ma; e_din = md; e_en = 1'b1; e_rd = (ms != 2'd2);
      end
    end
    e_busy = m_active;
    #1;
    compare_all();
    if (complete_data === 1'b1) dut_done_cnt++;
    if (Data_addr !== last_addr) begin last_addr = Data_addr; age = 0; end
    else age++;
    Data_dout = (age >= LAT - 1) ? mem[Data_addr] : 16'($urandom);
  endtask

  task automatic issue(input logic [1:0] ms, input logic [15:0] a, input logic [15:0] d);
    start = 1'b1; mem_state = ms; M_addr = a; M_data = d;
    step();
    start = 1'b0; mem_state = 2'd3;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (complete_data !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("rst_async_addr", Data_addr, 16'h0000);
    chk("rst_async_busy", {15'd0, busy}, 16'h0000);
    chk("rst_async_done", {15'd0, complete_data}, 16'h0000);
    step();
    reset = 1'b0;
  endtask

  int n, c0;
  logic [15:0] acc_exp;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    reset = 1'b1; start = 1'b0; mem_state = 2'd3; M_addr = 16'h0; M_data = 16'h0;
    Data_dout = mem[0];
    model_reset();
    #1;
    chk("rst_Data_addr", Data_addr, 16'h0000);
    chk("rst_Data_din", Data_din, 16'h0000);
    chk("rst_Data_rd", {15'd0, Data_rd}, 16'h0001);
    chk("rst_Data_en", {15'd0, Data_en}, 16'h0000);
    chk("rst_memout", memout, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_acc", acc_count, 16'h0000);
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();

    // plain read
    mem[16'h3000] = 16'hBEEF;
    issue(2'd0, 16'h3000, 16'h0000);
    chk("rd_addr", Data_addr, 16'h3000);
    chk("rd_rd", {15'd0, Data_rd}, 16'h0001);
    chk("rd_en", {15'd0, Data_en}, 16'h0001);
    wait_done(0, n);
    chk("rd_latency", 16'(n), 16'd2);
    chk("rd_memout", memout, 16'hBEEF);
    step();

    // indirect read
    mem[16'h3010] = 16'h4000;
    mem[16'h4000] = 16'h1234;
    issue(2'd1, 16'h3010, 16'h0000);
    chk("ind_addr0", Data_addr, 16'h3010);
    step(); step();
    chk("ind_addr1", Data_addr, 16'h4000);
    chk("ind_en_held", {15'd0, Data_en}, 16'h0001);
    wait_done(2, n);
    chk("ind_latency", 16'(n), 16'd4);
    chk("ind_memout", memout, 16'h1234);
    step();

    // write
    issue(2'd2, 16'h3020, 16'h00A5);
    chk("wr_en", {15'd0, Data_en}, 16'h0001);
    chk("wr_rd", {15'd0, Data_rd}, 16'h0000);
    chk("wr_din", Data_din, 16'h00A5);
    step();
    chk("wr_en_drop", {15'd0, Data_en}, 16'h0000);
    wait_done(1, n);
    chk("wr_latency", 16'(n), 16'd2);
    chk("wr_memout_kept", memout, 16'h1234);
    chk("wr_mem", mem[16'h3020], 16'h00A5);
    step();

    // start while busy is dropped
    mem[16'h3030] = 16'h5555;
    c0 = dut_done_cnt;
    issue(2'd0, 16'h3000, 16'h0000);
    start = 1'b1; mem_state = 2'd2; M_addr = 16'h3030; M_data = 16'hFFFF;
    step();
    start = 1'b0; mem_state = 2'd3;
    repeat (4) step();
    chk("busy_ign_count", 16'(dut_done_cnt - c0), 16'd1);
    chk("busy_ign_rd", {15'd0, Data_rd}, 16'h0001);
    chk("busy_ign_mem", mem[16'h3030], 16'h5555);

    // mem_state 3 is not an access
    c0 = dut_done_cnt;
    start = 1'b1; mem_state = 2'd3; M_addr = 16'h3040; M_data = 16'h1111;
    step();
    start = 1'b0;
    chk("none_busy", {15'd0, busy}, 16'h0000);
    repeat (3) step();
    chk("none_count", 16'(dut_done_cnt - c0), 16'd0);

    // reset in the middle of an indirect read
    issue(2'd1, 16'h3010, 16'h0000);
    step();
    c0 = dut_done_cnt;
    async_reset();
    repeat (5) step();
    chk("rst_ind_count", 16'(dut_done_cnt - c0), 16'd0);
    issue(2'd0, 16'h3000, 16'h0000);
    wait_done(0, n);
    chk("post_rst_latency", 16'(n), 16'd2);
    chk("post_rst_memout", memout, 16'hBEEF);
    step();
    issue(2'd2, 16'h3050, 16'h0F0F);
    wait_done(0, n);
    step();
    issue(2'd0, 16'h3050, 16'h0000);
    wait_done(0, n);
    chk("post_rst_rdback", memout, 16'h0F0F);
`ifdef MEM_ACCESS_RESP_CNT_EN
    acc_exp = 16'd3;
`else
    acc_exp = 16'd0;
`endif
    chk("acc_after_3", acc_count, acc_exp);
    step();

    // randomized traffic
    for (int i = 0; i < 700; i++) begin
      start = ($urandom_range(0, 2) == 0);
      mem_state = 2'($urandom_range(0, 3));
      M_addr = 16'h3000 + 16'($urandom_range(0, 15));
      M_data = 16'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        start = 1'b0;
        async_reset();
      end else begin
        step();
      end
    end
    start = 1'b0; mem_state = 2'd3;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
